// File: rtl/vga_pkg.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_pkg                                                      |
// | Description : Shared definitions for the VGA test-pattern generator:       |
// |               pattern-mode encodings and the colour-index to RGB mapping.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package vga_pkg;

  // Pattern-mode encodings, as presented on the mode input.
  localparam logic [2:0] MODE_VBAR    = 3'd0;
  localparam logic [2:0] MODE_HBAR    = 3'd1;
  localparam logic [2:0] MODE_XOR     = 3'd2;
  localparam logic [2:0] MODE_XNOR    = 3'd3;
  localparam logic [2:0] MODE_CHECKER = 3'd4;
  localparam logic [2:0] MODE_WHITE   = 3'd5;
  localparam logic [2:0] MODE_BORDER  = 3'd6;
  localparam logic [2:0] MODE_BLACK   = 3'd7;

  // Widest colour channel the mapping function supports.
  localparam int MAX_COLOR_W = 16;

  // Expand a 3-bit colour index into {R,G,B} with color_w bits per channel.
  // Every bit of a channel copies its index bit (R=c[2], G=c[1], B=c[0]).
  // The result is right-aligned: only the low 3*color_w bits are meaningful.
  function automatic logic [3*MAX_COLOR_W-1:0] color_expand(input logic [2:0] c,
                                                            input int         color_w);
    logic [3*MAX_COLOR_W-1:0] mask;
    logic [3*MAX_COLOR_W-1:0] rgb;
    mask = {(3*MAX_COLOR_W){1'b1}} >> (3*MAX_COLOR_W - color_w);
    rgb  = '0;
    if (c[0]) rgb = rgb | mask;
    if (c[1]) rgb = rgb | (mask << color_w);
    if (c[2]) rgb = rgb | (mask << (2 * color_w));
    return rgb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_timing                                                   |
// | Description : Pixel-clock divider plus horizontal/vertical counters and    |
// |               region decode for the VGA pattern generator.                 |
// | Revision    : 1.0 - initial release                                        |
// |                                                                            |
// | Ports                                                                      |
// |   clock        in   system clock, rising edge                              |
// |   rst_n        in   asynchronous active-low reset                          |
// |   o_pe         out  pixel enable (divider at its last count)               |
// |   o_frame_wrap out  counters sit on the last pixel of the frame            |
// |   o_origin     out  counters sit on (hcnt,vcnt) = (0,0)                    |
// |   o_x, o_y     out  active-area coordinates (valid when o_active)          |
// |   o_active     out  counters are inside the active area                    |
// |   o_hs_act     out  counters are inside the hsync interval                 |
// |   o_vs_act     out  counters are inside the vsync interval                 |
// +----------------------------------------------------------------------------+
module vga_timing #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CNT_W    = 11
) (
  input  logic             clock,
  input  logic             rst_n,
  output logic             o_pe,
  output logic             o_frame_wrap,
  output logic             o_origin,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_active,
  output logic             o_hs_act,
  output logic             o_vs_act
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  // A one-bit divider is kept for CLK_DIV=1; it simply stays at 0.
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] c_H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_H_START  = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] c_V_START  = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] c_H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] c_V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] c_H_SYNC   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] c_V_SYNC   = CNT_W'(V_SYNC);

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic             w_pe;
  logic             w_h_wrap;
  logic             w_v_wrap;

  assign w_pe     = (r_div == c_DIV_LAST);
  assign w_h_wrap = (r_hcnt == c_H_LAST);
  assign w_v_wrap = (r_vcnt == c_V_LAST);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else begin
      r_div <= w_pe ? '0 : r_div + DIV_W'(1);
      if (w_pe) begin
        if (w_h_wrap) begin
          r_hcnt <= '0;
          r_vcnt <= w_v_wrap ? '0 : r_vcnt + CNT_W'(1);
        end else begin
          r_hcnt <= r_hcnt + CNT_W'(1);
        end
      end
    end
  end

  // Coordinates wrap around outside the active area; they are only
  // meaningful while o_active is high.
  assign o_x = r_hcnt - c_H_START;
  assign o_y = r_vcnt - c_V_START;

  assign o_active     = (r_hcnt >= c_H_START) && (o_x < c_H_ACT) &&
                        (r_vcnt >= c_V_START) && (o_y < c_V_ACT);
  assign o_hs_act     = (r_hcnt < c_H_SYNC);
  assign o_vs_act     = (r_vcnt < c_V_SYNC);
  assign o_pe         = w_pe;
  assign o_frame_wrap = w_h_wrap && w_v_wrap;
  assign o_origin     = (r_hcnt == '0) && (r_vcnt == '0);

endmodule
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_pattern_gen                                              |
// | Description : Parametrised VGA timing and test-pattern generator. Eight    |
// |               pattern modes, switched only at frame wrap; all outputs are  |
// |               registered on the pixel enable so they stay pixel-aligned.   |
// | Revision    : 1.0 - initial release                                        |
// | Options     : define VGA_SCROLL_EN to scroll the x-based patterns by one   |
// |               pixel per frame.                                             |
// |                                                                            |
// | Ports                                                                      |
// |   clock        in   system clock, rising edge                              |
// |   rst_n        in   asynchronous active-low reset                          |
// |   mode[2:0]    in   pattern select, taken at frame wrap                    |
// |   disp_RGB     out  pixel colour {R,G,B}, COLOR_W bits each                |
// |   hsync        out  horizontal sync, active level HSYNC_POL               |
// |   vsync        out  vertical sync, active level VSYNC_POL                 |
// |   de           out  active-video qualifier                                |
// |   frame_start  out  one-clock strobe with the first pixel of a frame       |
// +----------------------------------------------------------------------------+
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int COLOR_W   = 1,   // 1..MAX_COLOR_W
  parameter int CLK_DIV   = 2,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int BARS      = 8,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CNT_W     = 11
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [2:0]           mode,
  output logic [3*COLOR_W-1:0] disp_RGB,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic                 frame_start
);

  localparam logic             c_HS_ON      = (HSYNC_POL != 0);
  localparam logic             c_VS_ON      = (VSYNC_POL != 0);
  localparam logic [CNT_W-1:0] c_BAR_W      = CNT_W'(H_ACTIVE / BARS);
  localparam logic [CNT_W-1:0] c_BAR_H      = CNT_W'(V_ACTIVE / BARS);
  localparam logic [CNT_W-1:0] c_BARS_LAST  = CNT_W'(BARS - 1);
  localparam logic [CNT_W-1:0] c_H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] c_V_ACT_LAST = CNT_W'(V_ACTIVE - 1);

  // ---------------------------------------------------------------- timing
  logic             w_pe;
  logic             w_frame_wrap;
  logic             w_origin;
  logic [CNT_W-1:0] w_x;
  logic [CNT_W-1:0] w_y;
  logic             w_active;
  logic             w_hs_act;
  logic             w_vs_act;

  vga_timing #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CNT_W    (CNT_W)
  ) u_timing (
    .clock        (clock),
    .rst_n        (rst_n),
    .o_pe         (w_pe),
    .o_frame_wrap (w_frame_wrap),
    .o_origin     (w_origin),
    .o_x          (w_x),
    .o_y          (w_y),
    .o_active     (w_active),
    .o_hs_act     (w_hs_act),
    .o_vs_act     (w_vs_act)
  );

  // The last pixel of the frame is always blank, so loading the mode on
  // that pixel switches patterns cleanly between frames.
  logic w_frame_tick;
  assign w_frame_tick = w_pe && w_frame_wrap;

  logic [2:0] r_mode_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q <= MODE_VBAR;
    end else if (w_frame_tick) begin
      r_mode_q <= mode;
    end
  end

  // ------------------------------------------------------- scrolled x
  logic [CNT_W-1:0] w_xs;

`ifdef VGA_SCROLL_EN
  localparam logic [CNT_W:0] c_H_ACT_EXT = (CNT_W+1)'(H_ACTIVE);

  logic [CNT_W-1:0] r_offset;
  logic [CNT_W:0]   w_xsum;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_offset <= '0;
    end else if (w_frame_tick) begin
      r_offset <= (r_offset == c_H_ACT_LAST) ? '0 : r_offset + CNT_W'(1);
    end
  end

  // x and offset are both below H_ACTIVE, so one conditional subtract
  // is enough for the modulo.
  assign w_xsum = {1'b0, w_x} + {1'b0, r_offset};
  assign w_xs   = (w_xsum >= c_H_ACT_EXT) ? CNT_W'(w_xsum - c_H_ACT_EXT)
                                          : CNT_W'(w_xsum);
`else
  assign w_xs = w_x;
`endif

  // ---------------------------------------------------------- patterns
  logic [CNT_W-1:0] w_vq;
  logic [CNT_W-1:0] w_hq;
  logic [2:0]       w_vcol;
  logic [2:0]       w_hcol;
  logic             w_border;
  logic [2:0]       w_cidx;

  // Bar index saturates at BARS-1 so any remainder pixels join the last bar.
  assign w_vq     = w_xs / c_BAR_W;
  assign w_hq     = w_y / c_BAR_H;
  assign w_vcol   = ~((w_vq > c_BARS_LAST) ? c_BARS_LAST[2:0] : w_vq[2:0]);
  assign w_hcol   = ~((w_hq > c_BARS_LAST) ? c_BARS_LAST[2:0] : w_hq[2:0]);
  assign w_border = (w_x == '0) || (w_x == c_H_ACT_LAST) ||
                    (w_y == '0) || (w_y == c_V_ACT_LAST);

  always_comb begin
    w_cidx = 3'b000;
    case (r_mode_q)
      MODE_VBAR:    w_cidx = w_vcol;
      MODE_HBAR:    w_cidx = w_hcol;
      MODE_XOR:     w_cidx = w_vcol ^ w_hcol;
      MODE_XNOR:    w_cidx = ~(w_vcol ^ w_hcol);
      MODE_CHECKER: w_cidx = {3{w_xs[5] ^ w_y[5]}};
      MODE_WHITE:   w_cidx = 3'b111;
      MODE_BORDER:  w_cidx = w_border ? 3'b111 : 3'b000;
      MODE_BLACK:   w_cidx = 3'b000;
      default:      w_cidx = 3'b000;
    endcase
  end

  logic [3*MAX_COLOR_W-1:0] w_rgb_full;
  logic [3*COLOR_W-1:0]     w_rgb;

  assign w_rgb_full = color_expand(w_cidx, COLOR_W);
  assign w_rgb      = w_rgb_full[3*COLOR_W-1:0];

  // The mapping is computed at the widest supported depth; the bits above
  // this instance's depth are always zero.
  if (COLOR_W < MAX_COLOR_W) begin : g_rgb_unused
    logic w_unused_rgb;
    assign w_unused_rgb = ^w_rgb_full[3*MAX_COLOR_W-1:3*COLOR_W];
  end

  // ------------------------------------------------------------ outputs
  logic [3*COLOR_W-1:0] r_rgb;
  logic                 r_hs;
  logic                 r_vs;
  logic                 r_de;
  logic                 r_fs;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb <= '0;
      r_hs  <= ~c_HS_ON;
      r_vs  <= ~c_VS_ON;
      r_de  <= 1'b0;
      r_fs  <= 1'b0;
    end else begin
      if (w_pe) begin
        r_rgb <= w_active ? w_rgb : '0;
        r_hs  <= w_hs_act ? c_HS_ON : ~c_HS_ON;
        r_vs  <= w_vs_act ? c_VS_ON : ~c_VS_ON;
        r_de  <= w_active;
      end
      // Strobe is a single system clock wide regardless of CLK_DIV.
      r_fs <= w_pe && w_origin;
    end
  end

  assign disp_RGB    = r_rgb;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign de          = r_de;
  assign frame_start = r_fs;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vga_pattern_gen                                           |
// | Description : Self-checking bench for vga_pattern_gen on a reduced         |
// |               geometry. Expected outputs come from an arithmetic model of  |
// |               the pixel stream indexed by clock edges since reset release. |
// | Revision    : 1.0 - initial release                                        |
// | Options     : honours VGA_SCROLL_EN in its model.                          |
// +----------------------------------------------------------------------------+
module tb_vga_pattern_gen;

  localparam int COLOR_W   = 2;
  localparam int CLK_DIV   = 2;
  localparam int H_ACTIVE  = 64;
  localparam int H_FP      = 4;
  localparam int H_SYNC    = 8;
  localparam int H_BP      = 6;
  localparam int V_ACTIVE  = 40;
  localparam int V_FP      = 2;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 3;
  localparam int BARS      = 8;
  localparam int HSYNC_POL = 1;
  localparam int VSYNC_POL = 0;
  localparam int CNT_W     = 8;

  localparam int HT = H_SYNC + H_BP + H_ACTIVE + H_FP;   // 82
  localparam int VT = V_SYNC + V_BP + V_ACTIVE + V_FP;   // 47
  localparam int FT = HT * VT;                           // pixels per frame
  localparam int N_FRAMES = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [2:0]           mode = 3'd0;
  logic [3*COLOR_W-1:0] disp_RGB;
  logic                 hsync;
  logic                 vsync;
  logic                 de;
  logic                 frame_start;

  vga_pattern_gen #(
    .COLOR_W   (COLOR_W),
    .CLK_DIV   (CLK_DIV),
    .H_ACTIVE  (H_ACTIVE),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_ACTIVE  (V_ACTIVE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP),
    .BARS      (BARS),
    .HSYNC_POL (HSYNC_POL),
    .VSYNC_POL (VSYNC_POL),
    .CNT_W     (CNT_W)
  ) dut (
    .clock       (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .disp_RGB    (disp_RGB),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int e;                 // rising edges since reset release
  int frame_mode[0:31];  // mode each frame is expected to show
  int perm[0:7];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int expand(input int c);
    int full;
    full = (1 << COLOR_W) - 1;
    return (((c >> 2) & 1) * full << (2 * COLOR_W)) |
           (((c >> 1) & 1) * full << COLOR_W) |
           ((c & 1) * full);
  endfunction

  function automatic logic [63:0] dut_vec();
    return 64'({disp_RGB, hsync, vsync, de, frame_start});
  endfunction

  // Output state after edge 'ed' counted from reset release.
  function automatic logic [63:0] model(input int ed);
    int j, l, h, v, f, x, y, xs, off, md, c, vi, hi, vcol, hcol, rgb;
    int hs, vs, act, fs;
    j = ed / CLK_DIV;
    if (j == 0)
      return 64'(((HSYNC_POL == 0) ? 8 : 0) | ((VSYNC_POL == 0) ? 4 : 0));
    l  = j - 1;                 // pixel presented after the j-th pixel edge
    h  = l % HT;
    v  = (l / HT) % VT;
    f  = l / FT;
    hs = (h < H_SYNC) ? HSYNC_POL : 1 - HSYNC_POL;
    vs = (v < V_SYNC) ? VSYNC_POL : 1 - VSYNC_POL;
    x  = h - (H_SYNC + H_BP);
    y  = v - (V_SYNC + V_BP);
    act = (x >= 0 && x < H_ACTIVE && y >= 0 && y < V_ACTIVE) ? 1 : 0;
    md  = frame_mode[f % 32];
`ifdef VGA_SCROLL_EN
    off = f % H_ACTIVE;
`else
    off = 0;
`endif
    xs = (x + off) % H_ACTIVE;
    vi = xs / (H_ACTIVE / BARS);
    if (vi > BARS - 1) vi = BARS - 1;
    hi = y / (V_ACTIVE / BARS);
    if (hi > BARS - 1) hi = BARS - 1;
    vcol = 7 - (vi % 8);
    hcol = 7 - (hi % 8);
    case (md)
      0: c = vcol;
      1: c = hcol;
      2: c = vcol ^ hcol;
      3: c = 7 - (vcol ^ hcol);
      4: c = (((xs / 32) % 2) != ((y / 32) % 2)) ? 7 : 0;
      5: c = 7;
      6: c = (x == 0 || x == H_ACTIVE - 1 || y == 0 || y == V_ACTIVE - 1) ? 7 : 0;
      default: c = 0;
    endcase
    rgb = act ? expand(c) : 0;
    fs  = ((ed % CLK_DIV) == 0 && h == 0 && v == 0) ? 1 : 0;
    return 64'((rgb << 4) | (hs << 3) | (vs << 2) | (act << 1) | fs);
  endfunction

  // Clock-count statistics over one frame window.
  int stat_start, stat_de, stat_vs, stat_fs, stat_hs;

  // Advance n edges, checking every one. 'sched' enables the per-frame
  // mode schedule: a junk value at line 20, the real choice at line 30.
  task automatic run_edges(input int n, input bit sched);
    int j, l, h, v, k;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      e++;
      j = e / CLK_DIV;
      // Mode present at the edge that shows the last pixel of a frame
      // governs the following frame.
      if ((e % CLK_DIV) == 0 && j > 0 && (j % FT) == 0)
        frame_mode[(j / FT) % 32] = int'(mode);
      check($sformatf("pix e=%0d", e), dut_vec(), model(e));
      if (e <= CLK_DIV)
        check($sformatf("fs_after_rst e=%0d", e), 64'(frame_start),
              64'((e == CLK_DIV) ? 1 : 0));
      if (e > stat_start && e <= stat_start + FT * CLK_DIV) begin
        stat_de += int'(de);
        stat_vs += (vsync == VSYNC_POL[0]) ? 1 : 0;
        stat_fs += int'(frame_start);
      end
      if (e > stat_start && e <= stat_start + HT * CLK_DIV)
        stat_hs += (hsync == HSYNC_POL[0]) ? 1 : 0;
      if (sched && (e % CLK_DIV) == 0 && j > 0) begin
        l = j;                  // pixel the counters hold now
        h = l % HT;
        v = (l / HT) % VT;
        k = l / FT;
        if (h == 0 && v == 20) mode = 3'($urandom_range(0, 7));
        if (h == 0 && v == 30) mode = 3'(perm[k % 8]);
      end
    end
  endtask

  initial begin
    int tmp, r;
    for (int i = 0; i < 8; i++) perm[i] = i;
    for (int i = 7; i > 0; i--) begin
      r = $urandom_range(0, i);
      tmp = perm[i]; perm[i] = perm[r]; perm[r] = tmp;
    end
    for (int i = 0; i < 32; i++) frame_mode[i] = 0;

    // Reset state while held.
    rst_n = 1'b0;
    mode  = 3'd3;
    repeat (3) @(posedge clk);
    #1;
    check("reset", dut_vec(), 64'(((HSYNC_POL == 0) ? 8 : 0) | ((VSYNC_POL == 0) ? 4 : 0)));

    // Frames with the mode schedule; frame 0 must be mode 0 regardless.
    stat_start = CLK_DIV * (FT + 1) + 7;
    stat_de = 0; stat_vs = 0; stat_fs = 0; stat_hs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    run_edges(N_FRAMES * FT * CLK_DIV + 50, 1'b1);

    check("de_clk_per_frame", 64'(stat_de), 64'(H_ACTIVE * V_ACTIVE * CLK_DIV));
    check("vs_clk_per_frame", 64'(stat_vs), 64'(V_SYNC * HT * CLK_DIV));
    check("fs_per_frame",     64'(stat_fs), 64'(1));
    check("hs_clk_per_line",  64'(stat_hs), 64'(H_SYNC * CLK_DIV));

    // Asynchronous reset in the middle of a line, away from clock edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", dut_vec(), 64'(((HSYNC_POL == 0) ? 8 : 0) | ((VSYNC_POL == 0) ? 4 : 0)));
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", dut_vec(), 64'(((HSYNC_POL == 0) ? 8 : 0) | ((VSYNC_POL == 0) ? 4 : 0)));

    // After release the first frame is mode 0 even with another mode applied.
    for (int i = 0; i < 32; i++) frame_mode[i] = 0;
    mode = 3'd5;
    stat_start = 1 << 30;
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    run_edges(FT * CLK_DIV + HT * CLK_DIV * 12, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
